rv_dmem_arb: RTL and testbench

//  Two-master arbiter for the data (B) port of the program/data dpram. Shares it between
//  the rv_core data bus and a secondary loader/debug master (e.g. UART boot loader).
//  The core has priority. A starvation counter guarantees the loader forward progress.

---
 rtl/rv_dmem_arb_if.sv | 45 ++++
 rtl/rv_dmem_arb.sv | 90 +++++++++
 tb/tb_rv_dmem_arb.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_dmem_arb_if.sv
// Bus bundle for the dpram port-B arbiter: core data bus, loader/debug bus and RAM port B.
// The arbiter takes the slave view; the surrounding core/loader/RAM environment takes the master view.
interface rv_dmem_arb_if #(
   parameter int AW = 15
);
   // core data bus
   logic [31:0]   c_adr;
   logic          c_re;
   logic [3:0]    c_we;
   logic [31:0]   c_dw;
   logic [31:0]   c_dr;
   logic          c_rdy;
   // loader / debug bus
   logic [31:0]   l_adr;
   logic          l_re;
   logic [3:0]    l_we;
   logic [31:0]   l_dw;
   logic          l_gnt;
   logic          l_ack;
   logic [31:0]   l_dr;
   // RAM port B
   logic          m_ena;
   logic [3:0]    m_we;
   logic [AW-3:0] m_adr;
   logic [31:0]   m_dw;
   logic [31:0]   m_dr;

   modport slave (
      input  c_adr, c_re, c_we, c_dw,
      output c_dr, c_rdy,
      input  l_adr, l_re, l_we, l_dw,
      output l_gnt, l_ack, l_dr,
      output m_ena, m_we, m_adr, m_dw,
      input  m_dr
   );

   modport master (
      output c_adr, c_re, c_we, c_dw,
      input  c_dr, c_rdy,
      output l_adr, l_re, l_we, l_dw,
      input  l_gnt, l_ack, l_dr,
      input  m_ena, m_we, m_adr, m_dw,
      output m_dr
   );
endinterface

// File: rtl/rv_dmem_arb.sv
// Core/loader arbiter for dpram port B: core has priority, a wait counter lets a starved
// loader pre-empt one core access. Read data returns one cycle after the grant.
module rv_dmem_arb #(
   parameter int AW         = 15,
   parameter int STARVE_LIM = 4
) (
   input  logic         clk,
   input  logic         reset,
   rv_dmem_arb_if.slave bus
);
   localparam int WW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   typedef struct packed {
      logic [31:0] adr;
      logic        re;
      logic [3:0]  we;
      logic [31:0] dw;
   } req_t;

   function automatic logic in_win(input logic [31:0] a);
      return (a >> AW) == 32'd0;
   endfunction

   req_t          creq_s, lreq_s;
   logic          c_op, l_op, creq, lreq, starved;
   logic          core_gnt, loader_gnt;
   logic [WW-1:0] wcnt;
   logic [1:0]    rsel;
   logic          l_ack_q;
   logic [31:0]   c_dr_q;
   logic          unused_adr_lsb;

   assign creq_s = '{adr: bus.c_adr, re: bus.c_re, we: bus.c_we, dw: bus.c_dw};
   assign lreq_s = '{adr: bus.l_adr, re: bus.l_re, we: bus.l_we, dw: bus.l_dw};

   assign c_op = creq_s.re | (|creq_s.we);
   assign l_op = lreq_s.re | (|lreq_s.we);
   assign creq = c_op & in_win(creq_s.adr);
   assign lreq = l_op & in_win(lreq_s.adr);

   // Loader wins alone, or when it has waited STARVE_LIM cycles against the core.
   assign starved    = (wcnt == WW'(STARVE_LIM));
   assign loader_gnt = ~reset & lreq & (~creq | starved);
   assign core_gnt   = ~reset & creq & ~loader_gnt;

   assign bus.c_rdy = reset | ~(creq & ~core_gnt);
   assign bus.l_gnt = loader_gnt;
   assign bus.m_ena = core_gnt | loader_gnt;

   always_comb begin
      bus.m_we  = '0;
      bus.m_adr = '0;
      bus.m_dw  = '0;
      if (core_gnt) begin
         bus.m_we  = creq_s.we;
         bus.m_adr = creq_s.adr[AW-1:2];
         bus.m_dw  = creq_s.dw;
      end else if (loader_gnt) begin
         bus.m_we  = lreq_s.we;
         bus.m_adr = lreq_s.adr[AW-1:2];
         bus.m_dw  = lreq_s.dw;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt    <= '0;
         rsel    <= '0;
         l_ack_q <= 1'b0;
         c_dr_q  <= '0;
      end else begin
         if (~lreq | loader_gnt)
            wcnt <= '0;
         else if (!starved)
            wcnt <= wcnt + WW'(1);
         rsel    <= {core_gnt & creq_s.re, loader_gnt & lreq_s.re};
         // out-of-window loader accesses are acked without touching the RAM
         l_ack_q <= loader_gnt | (l_op & ~in_win(lreq_s.adr));
         if (rsel[1])
            c_dr_q <= bus.m_dr;
      end
   end

   // Gating with reset keeps a grant from the cycle before reset from surfacing.
   assign bus.l_ack = l_ack_q & ~reset;
   assign bus.c_dr  = (rsel[1] & ~reset) ? bus.m_dr : c_dr_q;
   assign bus.l_dr  = (rsel[0] & ~reset) ? bus.m_dr : 32'd0;

   assign unused_adr_lsb = ^{creq_s.adr[1:0], lreq_s.adr[1:0]};
endmodule

// File: tb/tb_rv_dmem_arb.sv
// Self-checking bench for rv_dmem_arb: directed scenarios plus a randomized run against
// a transaction-level model of priority, starvation and one-cycle read return.
module tb_rv_dmem_arb;
   localparam int AW  = 15;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rv_dmem_arb_if #(.AW(AW)) bus ();
   rv_dmem_arb #(.AW(AW), .STARVE_LIM(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));

   // dpram port B: 1-cycle read latency, read-old on simultaneous write
   logic [31:0] ram [0:(1<<(AW-2))-1];
   always @(posedge clk) begin
      if (bus.m_ena) begin
         bus.m_dr <= ram[bus.m_adr];
         for (int b = 0; b < 4; b++)
            if (bus.m_we[b]) ram[bus.m_adr][8*b +: 8] <= bus.m_dw[8*b +: 8];
      end
   end

   task automatic idle();
      bus.c_adr = '0; bus.c_re = 1'b0; bus.c_we = '0; bus.c_dw = '0;
      bus.l_adr = '0; bus.l_re = 1'b0; bus.l_we = '0; bus.l_dw = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.c_re = 1'b1; bus.c_adr = 32'h100;
      bus.l_re = 1'b1; bus.l_adr = 32'h8;
      @(negedge clk);
      n_chk++; if (bus.m_ena !== 1'b0) begin n_fail++; $display("FAIL rst_m_ena got %0b exp 0", bus.m_ena); end
      n_chk++; if (bus.m_we !== 4'h0) begin n_fail++; $display("FAIL rst_m_we got %h exp 0", bus.m_we); end
      n_chk++; if (bus.l_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_l_gnt got %0b exp 0", bus.l_gnt); end
      n_chk++; if (bus.c_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_c_rdy got %0b exp 1", bus.c_rdy); end
      step(); step();
      reset = 1'b0;
      idle();
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b0) begin n_fail++; $display("FAIL rst_l_ack got %0b exp 0", bus.l_ack); end
      n_chk++; if (bus.c_dr !== 32'h0) begin n_fail++; $display("FAIL rst_c_dr got %h exp 0", bus.c_dr); end
      n_chk++; if (bus.l_dr !== 32'h0) begin n_fail++; $display("FAIL rst_l_dr got %h exp 0", bus.l_dr); end
      step();
   endtask

   task automatic test_core_read();
      idle();
      bus.c_we = 4'hF; bus.c_adr = 32'h100; bus.c_dw = 32'hDEADBEEF;
      @(negedge clk);
      n_chk++; if (bus.m_ena !== 1'b1) begin n_fail++; $display("FAIL cw_m_ena got %0b exp 1", bus.m_ena); end
      n_chk++; if (bus.m_we !== 4'hF) begin n_fail++; $display("FAIL cw_m_we got %h exp f", bus.m_we); end
      step();
      bus.c_we = 4'h0; bus.c_re = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.c_rdy !== 1'b1) begin n_fail++; $display("FAIL cr_c_rdy got %0b exp 1", bus.c_rdy); end
      n_chk++; if (bus.m_adr !== 13'h40) begin n_fail++; $display("FAIL cr_m_adr got %h exp 40", bus.m_adr); end
      n_chk++; if (bus.m_we !== 4'h0) begin n_fail++; $display("FAIL cr_m_we got %h exp 0", bus.m_we); end
      n_chk++; if (bus.l_gnt !== 1'b0) begin n_fail++; $display("FAIL cr_l_gnt got %0b exp 0", bus.l_gnt); end
      step();
      idle();
      @(negedge clk);
      n_chk++; if (bus.c_dr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cr_c_dr got %h exp deadbeef", bus.c_dr); end
      step();
      @(negedge clk);
      n_chk++; if (bus.c_dr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cr_c_dr_hold got %h exp deadbeef", bus.c_dr); end
      step();
   endtask

   task automatic test_loader_rw();
      idle();
      bus.l_we = 4'hF; bus.l_adr = 32'h8; bus.l_dw = 32'h12345678;
      @(negedge clk);
      n_chk++; if (bus.l_gnt !== 1'b1) begin n_fail++; $display("FAIL lw_l_gnt got %0b exp 1", bus.l_gnt); end
      n_chk++; if (bus.m_adr !== 13'h2) begin n_fail++; $display("FAIL lw_m_adr got %h exp 2", bus.m_adr); end
      n_chk++; if (bus.m_dw !== 32'h12345678) begin n_fail++; $display("FAIL lw_m_dw got %h exp 12345678", bus.m_dw); end
      step();
      bus.l_we = 4'h0; bus.l_re = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.l_gnt !== 1'b1) begin n_fail++; $display("FAIL lr_l_gnt got %0b exp 1", bus.l_gnt); end
      n_chk++; if (bus.l_ack !== 1'b1) begin n_fail++; $display("FAIL lw_l_ack got %0b exp 1", bus.l_ack); end
      step();
      idle();
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b1) begin n_fail++; $display("FAIL lr_l_ack got %0b exp 1", bus.l_ack); end
      n_chk++; if (bus.l_dr !== 32'h12345678) begin n_fail++; $display("FAIL lr_l_dr got %h exp 12345678", bus.l_dr); end
      step();
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b0) begin n_fail++; $display("FAIL lr_l_ack_drop got %0b exp 0", bus.l_ack); end
      n_chk++; if (bus.l_dr !== 32'h0) begin n_fail++; $display("FAIL lr_l_dr_idle got %h exp 0", bus.l_dr); end
      step();
   endtask

   task automatic test_contention();
      logic g;
      idle();
      bus.c_re = 1'b1; bus.c_adr = 32'h100;
      bus.l_re = 1'b1; bus.l_adr = 32'h8;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         g = (cyc == 4) || (cyc == 9);
         @(negedge clk);
         n_chk++; if (bus.l_gnt !== g) begin n_fail++; $display("FAIL ct_l_gnt cyc=%0d got %0b exp %0b", cyc, bus.l_gnt, g); end
         n_chk++; if (bus.c_rdy !== !g) begin n_fail++; $display("FAIL ct_c_rdy cyc=%0d got %0b exp %0b", cyc, bus.c_rdy, !g); end
         n_chk++; if (bus.l_ack !== (cyc == 5 || cyc == 10)) begin n_fail++; $display("FAIL ct_l_ack cyc=%0d got %0b", cyc, bus.l_ack); end
         if (cyc == 5) begin
            n_chk++; if (dut.wcnt !== '0) begin n_fail++; $display("FAIL ct_wcnt got %0d exp 0", dut.wcnt); end
            n_chk++; if (bus.l_dr !== 32'h12345678) begin n_fail++; $display("FAIL ct_l_dr got %h exp 12345678", bus.l_dr); end
            n_chk++; if (bus.c_dr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ct_c_dr_hold got %h exp deadbeef", bus.c_dr); end
         end
         step();
      end
      idle();
      step(); step();
   endtask

   task automatic test_out_of_window();
      idle();
      bus.c_re = 1'b1; bus.c_adr = 32'hFFFF0000;
      @(negedge clk);
      n_chk++; if (bus.c_rdy !== 1'b1) begin n_fail++; $display("FAIL oow_c_rdy got %0b exp 1", bus.c_rdy); end
      n_chk++; if (bus.m_ena !== 1'b0) begin n_fail++; $display("FAIL oow_c_m_ena got %0b exp 0", bus.m_ena); end
      step();
      idle();
      bus.c_we = 4'hF; bus.c_adr = 32'h8000;
      @(negedge clk);
      n_chk++; if (bus.m_ena !== 1'b0) begin n_fail++; $display("FAIL oow_edge_m_ena got %0b exp 0", bus.m_ena); end
      step();
      bus.c_we = 4'h0; bus.c_re = 1'b1; bus.c_adr = 32'h7FFC;
      @(negedge clk);
      n_chk++; if (bus.m_ena !== 1'b1 || bus.m_adr !== 13'h1FFF) begin n_fail++; $display("FAIL win_top got ena=%0b adr=%h exp 1/1fff", bus.m_ena, bus.m_adr); end
      step();
      idle();
      bus.l_re = 1'b1; bus.l_adr = 32'h20000;
      @(negedge clk);
      n_chk++; if (bus.m_ena !== 1'b0) begin n_fail++; $display("FAIL oow_l_m_ena got %0b exp 0", bus.m_ena); end
      n_chk++; if (bus.l_gnt !== 1'b0) begin n_fail++; $display("FAIL oow_l_gnt got %0b exp 0", bus.l_gnt); end
      step();
      idle();
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b1) begin n_fail++; $display("FAIL oow_l_ack got %0b exp 1", bus.l_ack); end
      n_chk++; if (bus.l_dr !== 32'h0) begin n_fail++; $display("FAIL oow_l_dr got %h exp 0", bus.l_dr); end
      step();
   endtask

   task automatic test_byte_en();
      idle();
      bus.c_we = 4'hF; bus.c_adr = 32'h200; bus.c_dw = 32'h11223344;
      step();
      bus.c_we = 4'b0101; bus.c_dw = 32'hAABBCCDD;
      step();
      bus.c_we = 4'h0; bus.c_re = 1'b1;
      step();
      idle();
      @(negedge clk);
      n_chk++; if (bus.c_dr !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_c_dr got %h exp 11bb33dd", bus.c_dr); end
      step();
   endtask

   task automatic test_reset_mid();
      logic g;
      idle();
      bus.l_re = 1'b1; bus.l_adr = 32'h8;
      @(negedge clk);
      n_chk++; if (bus.l_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_l_gnt got %0b exp 1", bus.l_gnt); end
      step();
      reset = 1'b1;
      idle();
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b0) begin n_fail++; $display("FAIL rm_l_ack_in_rst got %0b exp 0", bus.l_ack); end
      n_chk++; if (bus.l_dr !== 32'h0) begin n_fail++; $display("FAIL rm_l_dr_in_rst got %h exp 0", bus.l_dr); end
      step();
      reset = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.l_ack !== 1'b0) begin n_fail++; $display("FAIL rm_l_ack got %0b exp 0", bus.l_ack); end
      n_chk++; if (bus.c_dr !== 32'h0) begin n_fail++; $display("FAIL rm_c_dr got %h exp 0", bus.c_dr); end
      n_chk++; if (dut.wcnt !== '0) begin n_fail++; $display("FAIL rm_wcnt got %0d exp 0", dut.wcnt); end
      bus.c_re = 1'b1; bus.c_adr = 32'h200;
      step();
      idle();
      @(negedge clk);
      n_chk++; if (bus.c_dr !== 32'h11BB33DD) begin n_fail++; $display("FAIL rm_post_c_dr got %h exp 11bb33dd", bus.c_dr); end
      // partial starvation must be forgotten across reset
      bus.c_re = 1'b1; bus.c_adr = 32'h100;
      bus.l_re = 1'b1; bus.l_adr = 32'h8;
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int cyc = 0; cyc <= 4; cyc++) begin
         g = (cyc == 4);
         @(negedge clk);
         n_chk++; if (bus.l_gnt !== g) begin n_fail++; $display("FAIL rm_starve cyc=%0d got %0b exp %0b", cyc, bus.l_gnt, g); end
         step();
      end
      idle();
      step(); step();
   endtask

   task automatic test_random();
      logic [31:0] ref_mem [0:15];
      logic [31:0] ca, cd, la, ld, exp_cdr, exp_ldr, v;
      logic [3:0]  cwe, lwe, ewe;
      logic [12:0] eadr;
      logic        cp, cre, lp, lre, exp_lack, cin, lin, creq_m, lreq_m, cwin, lwin;
      int          lwait;
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         ref_mem[i] = v;
         bus.c_we = 4'hF; bus.c_adr = 32'h400 + 32'(i * 4); bus.c_dw = v;
         step();
      end
      idle();
      step();
      exp_cdr = '0; exp_ldr = '0; exp_lack = 1'b0;
      cp = 1'b0; lp = 1'b0; lwait = 0;
      ca = '0; cd = '0; cre = 1'b0; cwe = '0;
      la = '0; ld = '0; lre = 1'b0; lwe = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!cp && $urandom_range(0, 3) != 0) begin
            cp  = 1'b1;
            ca  = ($urandom_range(0, 9) == 0) ? 32'h8000 + 32'($urandom_range(0, 255) * 4)
                                              : 32'h400 + 32'($urandom_range(0, 15) * 4);
            cre = 1'($urandom_range(0, 1));
            cwe = 4'($urandom_range(0, 15));
            if (!cre && cwe == 4'h0) cre = 1'b1;
            cd  = $urandom;
         end
         if (!lp && $urandom_range(0, 1) != 0) begin
            lp  = 1'b1;
            la  = ($urandom_range(0, 9) == 0) ? 32'h20000 + 32'($urandom_range(0, 255) * 4)
                                              : 32'h400 + 32'($urandom_range(0, 15) * 4);
            lre = 1'($urandom_range(0, 1));
            lwe = 4'($urandom_range(0, 15));
            if (!lre && lwe == 4'h0) lre = 1'b1;
            ld  = $urandom;
         end
         bus.c_adr = cp ? ca : '0; bus.c_re = cp & cre; bus.c_we = cp ? cwe : '0; bus.c_dw = cp ? cd : '0;
         bus.l_adr = lp ? la : '0; bus.l_re = lp & lre; bus.l_we = lp ? lwe : '0; bus.l_dw = lp ? ld : '0;
         cin    = ca < 32'h8000;
         lin    = la < 32'h8000;
         creq_m = cp && cin;
         lreq_m = lp && lin;
         lwin   = lreq_m && (!creq_m || lwait >= LIM);
         cwin   = creq_m && !lwin;
         eadr   = cwin ? ca[14:2] : lwin ? la[14:2] : 13'h0;
         ewe    = cwin ? cwe : lwin ? lwe : 4'h0;
         @(negedge clk);
         n_chk++; if (bus.c_rdy !== !(creq_m && !cwin)) begin n_fail++; $display("FAIL rnd_c_rdy cyc=%0d got %0b", cyc, bus.c_rdy); end
         n_chk++; if (bus.l_gnt !== lwin) begin n_fail++; $display("FAIL rnd_l_gnt cyc=%0d got %0b exp %0b", cyc, bus.l_gnt, lwin); end
         n_chk++; if (bus.m_ena !== (cwin | lwin)) begin n_fail++; $display("FAIL rnd_m_ena cyc=%0d got %0b", cyc, bus.m_ena); end
         n_chk++; if (bus.m_adr !== eadr) begin n_fail++; $display("FAIL rnd_m_adr cyc=%0d got %h exp %h", cyc, bus.m_adr, eadr); end
         n_chk++; if (bus.m_we !== ewe) begin n_fail++; $display("FAIL rnd_m_we cyc=%0d got %h exp %h", cyc, bus.m_we, ewe); end
         n_chk++; if (bus.l_ack !== exp_lack) begin n_fail++; $display("FAIL rnd_l_ack cyc=%0d got %0b exp %0b", cyc, bus.l_ack, exp_lack); end
         n_chk++; if (bus.l_dr !== exp_ldr) begin n_fail++; $display("FAIL rnd_l_dr cyc=%0d got %h exp %h", cyc, bus.l_dr, exp_ldr); end
         n_chk++; if (bus.c_dr !== exp_cdr) begin n_fail++; $display("FAIL rnd_c_dr cyc=%0d got %h exp %h", cyc, bus.c_dr, exp_cdr); end
         exp_ldr  = (lwin && lre) ? ref_mem[la[5:2]] : 32'h0;
         exp_lack = lwin || (lp && !lin);
         if (cwin && cre) exp_cdr = ref_mem[ca[5:2]];
         for (int b = 0; b < 4; b++) begin
            if (cwin && cwe[b]) ref_mem[ca[5:2]][8*b +: 8] = cd[8*b +: 8];
            if (lwin && lwe[b]) ref_mem[la[5:2]][8*b +: 8] = ld[8*b +: 8];
         end
         lwait = (lreq_m && !lwin) ? ((lwait < LIM) ? lwait + 1 : LIM) : 0;
         if (!creq_m || cwin) cp = 1'b0;
         if (lwin || (lp && !lin)) lp = 1'b0;
         step();
      end
      idle();
      step();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_core_read();
      test_loader_rw();
      test_contention();
      test_out_of_window();
      test_byte_en();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
